// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared encodings for the micro-sequencer.
//   ADDR_W  : control-store address width (5)
//   nsel_e  : next-address select encodings
//   cc_e    : condition select encodings (flags are {N,Z,V,C})
//   fsm_e   : sequencer run state
package micro_seq_pkg;
    localparam int ADDR_W = 5;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [2:0] {
        NS_NEXT     = 3'b000,
        NS_JUMP     = 3'b001,
        NS_BRANCH   = 3'b010,
        NS_FETCH    = 3'b011,
        NS_WAIT_MOC = 3'b100,
        NS_HALT     = 3'b101,
        NS_CALL     = 3'b110,
        NS_RET      = 3'b111
    } nsel_e;
    typedef enum logic [1:0] {CC_Z = 2'b00, CC_N = 2'b01, CC_C = 2'b10, CC_V = 2'b11} cc_e;
    typedef enum logic [1:0] {ST_RUN = 2'b00, ST_WAIT = 2'b01, ST_HALT = 2'b10} fsm_e;
endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: microinstruction fields in, sequencer status out.
//   master : drives ena, n_sel, cr_addr, cc_sel, inv, flags, moc, go
//   slave  : the sequencer; drives state_addr, inc_addr, halted, stk_err
interface micro_sequencer_if;
    import micro_seq_pkg::*;
    logic        ena;
    logic [2:0]  n_sel;
    addr_t       cr_addr;
    logic [1:0]  cc_sel;
    logic        inv;
    logic [3:0]  flags;
    logic        moc;
    logic        go;
    addr_t       state_addr;
    addr_t       inc_addr;
    logic        halted;
    logic        stk_err;
    modport master (output ena, n_sel, cr_addr, cc_sel, inv, flags, moc, go,
                    input state_addr, inc_addr, halted, stk_err);
    modport slave  (input ena, n_sel, cr_addr, cc_sel, inv, flags, moc, go,
                    output state_addr, inc_addr, halted, stk_err);
endinterface

// File: rtl/micro_ret_stack.sv
// micro_ret_stack: 2-entry return-address stack.
//   clk, rst_n : clock, async active-low reset (empties the stack)
//   push, pop  : one-cycle strobes, never both at once
//   din, dout  : address pushed / current top of stack
//   full, empty: occupancy flags; a push when full drops the oldest entry
import micro_seq_pkg::*;
module micro_ret_stack (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  addr_t din,
    output addr_t dout,
    output logic  full,
    output logic  empty
);
    addr_t      top_q, bot_q;
    logic [1:0] cnt_q;
    assign full  = cnt_q == 2'd2;
    assign empty = cnt_q == 2'd0;
    assign dout  = top_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
            bot_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            top_q <= din;
            bot_q <= top_q;
            cnt_q <= full ? 2'd2 : cnt_q + 2'd1;
        end else if (pop && !empty) begin
            top_q <= bot_q;
            cnt_q <= cnt_q - 2'd1;
        end
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram address sequencer with RUN/WAIT/HALT control.
//   clk, rst_n : clock, async active-low reset (addr 0, inc 1, RUN, stack empty)
//   bus        : micro_sequencer_if.slave; ena freezes everything when low,
//                n_sel/cr_addr/cc_sel/inv/flags pick the next address,
//                moc ends WAIT, go ends HALT; state_addr/inc_addr/halted/stk_err out
// Optional feature: define MICRO_SEQ_RET_STACK_EN for CALL/RET with a 2-entry
// return stack; otherwise CALL/RET behave as NEXT and stk_err stays 0.
import micro_seq_pkg::*;
module micro_sequencer (
    input  logic clk,
    input  logic rst_n,
    micro_sequencer_if.slave bus
);
    fsm_e  state_q, state_d;
    addr_t addr_q, inc_q, next_addr;
    logic  halted_q, err_q, err_d;
    logic  cond;
    nsel_e op;
    cc_e   cc;
`ifdef MICRO_SEQ_RET_STACK_EN
    logic  do_push, do_pop, stk_full, stk_empty;
    addr_t stk_dout;
`endif
    assign op = nsel_e'(bus.n_sel);
    assign cc = cc_e'(bus.cc_sel);
    // flags are packed {N,Z,V,C}
    assign cond = cc == CC_Z ? bus.flags[2] :
                  cc == CC_N ? bus.flags[3] :
                  cc == CC_C ? bus.flags[0] : bus.flags[1];
    always_comb begin
        state_d   = state_q;
        next_addr = addr_q;
        err_d     = err_q;
`ifdef MICRO_SEQ_RET_STACK_EN
        do_push   = 1'b0;
        do_pop    = 1'b0;
`endif
        case (state_q)
            ST_WAIT: begin
                if (bus.moc) begin
                    state_d   = ST_RUN;
                    next_addr = inc_q;
                end
            end
            ST_HALT: begin
                if (bus.go) begin
                    state_d   = ST_RUN;
                    next_addr = inc_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                case (op)
                    NS_JUMP:   next_addr = bus.cr_addr;
                    NS_BRANCH: next_addr = (cond ^ bus.inv) ? bus.cr_addr : inc_q;
                    NS_FETCH:  next_addr = '0;
                    // moc already high on the decode edge skips WAIT entirely
                    NS_WAIT_MOC: begin
                        if (bus.moc) next_addr = inc_q;
                        else state_d = ST_WAIT;
                    end
                    NS_HALT:   state_d = ST_HALT;
`ifdef MICRO_SEQ_RET_STACK_EN
                    NS_CALL: begin
                        do_push   = 1'b1;
                        next_addr = bus.cr_addr;
                        err_d     = err_q | stk_full;
                    end
                    NS_RET: begin
                        do_pop    = 1'b1;
                        next_addr = stk_empty ? '0 : stk_dout;
                        err_d     = err_q | stk_empty;
                    end
`endif
                    default:   next_addr = inc_q;
                endcase
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            addr_q   <= '0;
            inc_q    <= addr_t'(1);
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (bus.ena) begin
            state_q  <= state_d;
            addr_q   <= next_addr;
            inc_q    <= next_addr + addr_t'(1);
            halted_q <= state_d == ST_HALT;
            err_q    <= err_d;
        end
    end
`ifdef MICRO_SEQ_RET_STACK_EN
    micro_ret_stack u_stk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (do_push & bus.ena),
        .pop   (do_pop & bus.ena),
        .din   (inc_q),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );
`endif
    assign bus.state_addr = addr_q;
    assign bus.inc_addr   = inc_q;
    assign bus.halted     = halted_q;
    assign bus.stk_err    = err_q;
endmodule
